// File: rtl/lagged_pair_averager.sv
// lagged_pair_averager: streaming average of each accepted sample with the
// sample accepted LAG positions earlier. History lives in a LAG-entry circular
// buffer; results leave through a single registered valid/ready stage.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and data stable until that edge. in_ready
// depends combinationally on out_ready, and out_data stays fixed while
// out_valid && !out_ready.
module lagged_pair_averager #(
    parameter int DATA_W = 8,
    parameter int LAG    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        rnd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              primed
);

    // A LAG of 1 still gets a 1-bit pointer so the declarations stay legal.
    localparam int PTR_W  = (LAG > 1) ? $clog2(LAG) : 1;
    localparam int FILL_W = $clog2(LAG + 1);
    localparam logic [PTR_W-1:0]  WP_LAST   = PTR_W'(LAG - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LAG);

    logic [DATA_W-1:0] hist_q [LAG];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              accept;
    logic              load;
    logic              hist_we;
    logic [DATA_W-1:0] old_sample;
    logic [DATA_W:0]   sum;
    logic              round_inc;
    logic [DATA_W:0]   avg_full;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign primed     = (fill_q == FILL_FULL);
    assign old_sample = hist_q[wp_q];
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    // Full-width sum and rounding; the halved sum plus one never exceeds 2^DATA_W-1.
    always_comb begin
        sum = {1'b0, old_sample} + {1'b0, in_data};
        case (rnd_mode)
            2'b00:   round_inc = 1'b0;
            2'b10:   round_inc = sum[0] & sum[1];
            default: round_inc = sum[0];
        endcase
        avg_full = {1'b0, sum[DATA_W:1]} + {{DATA_W{1'b0}}, round_inc};
    end

    // Pointer, fill level and output register next-state; clear beats accept.
    always_comb begin
        wp_d        = wp_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        load        = 1'b0;
        hist_we     = 1'b0;
        if (clear) begin
            wp_d        = '0;
            fill_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                hist_we = 1'b1;
                wp_d    = (wp_q == WP_LAST) ? '0 : wp_q + PTR_W'(1);
                if (fill_q == FILL_FULL) begin
                    load = 1'b1;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            if (load) begin
                out_valid_d = 1'b1;
                out_data_d  = avg_full[DATA_W-1:0];
            end
        end
    end

    // State registers and history buffer write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q        <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < LAG; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            wp_q        <= wp_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (hist_we) begin
                hist_q[wp_q] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_lagged_pair_averager.sv
// Bench for lagged_pair_averager: three instances (LAG 8, 5, 1) share clock,
// reset, clear and rnd_mode; each has its own stream and a reference model
// that feeds an expected-result queue checked when the DUT hands out data.
module tb_lagged_pair_averager;

    localparam int DW = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic reset, clear;
    logic [1:0] rnd_mode;
    logic [NI-1:0] in_valid, in_ready, out_valid, out_ready, primed;
    logic [NI-1:0][DW-1:0] in_data, out_data;

    int total = 0;
    int bad   = 0;

    int lag_c [NI] = '{8, 5, 1};
    logic [DW-1:0] m_hist [NI][8];
    int m_wp [NI];
    int m_fill [NI];
    logic [DW-1:0] exp_q [NI][$];
    int n_out [NI];
    logic acc [NI];
    logic stall_v [NI];
    logic [DW-1:0] stall_d [NI];

    always #5 clk = ~clk;

    lagged_pair_averager #(.DATA_W(DW), .LAG(8)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .rnd_mode(rnd_mode), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .primed(primed[0]));
    lagged_pair_averager #(.DATA_W(DW), .LAG(5)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .rnd_mode(rnd_mode), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .primed(primed[1]));
    lagged_pair_averager #(.DATA_W(DW), .LAG(1)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .rnd_mode(rnd_mode), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .primed(primed[2]));

    // Reference rounding worked on integers.
    function automatic logic [DW-1:0] ref_avg(input int a, input int b, input int mode);
        int s, h, r;
        s = a + b;
        h = s / 2;
        case (mode)
            0:       r = h;
            2:       r = h + (((s % 2) == 1 && (h % 2) == 1) ? 1 : 0);
            default: r = h + (s % 2);
        endcase
        return r[DW-1:0];
    endfunction

    // One clock: at the falling edge observe the handshakes the next rising
    // edge will commit, update models, then return 1 time unit after that edge.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            acc[i] = 1'b0;
            if (reset) begin
                m_fill[i] = 0;
                m_wp[i] = 0;
                exp_q[i].delete();
                stall_v[i] = 1'b0;
            end else begin
                total++;
                if (in_ready[i] !== (!out_valid[i] || out_ready[i])) begin
                    bad++;
                    $display("FAIL in_ready_formula[%0d]: got %b want %b", i, in_ready[i], !out_valid[i] || out_ready[i]);
                end
                total++;
                if (primed[i] !== (m_fill[i] == lag_c[i])) begin
                    bad++;
                    $display("FAIL primed[%0d]: got %b want %b", i, primed[i], m_fill[i] == lag_c[i]);
                end
                if (stall_v[i]) begin
                    total++;
                    if (out_valid[i] !== 1'b1 || out_data[i] !== stall_d[i]) begin
                        bad++;
                        $display("FAIL stall_hold[%0d]: got v=%b d=%0d want v=1 d=%0d", i, out_valid[i], out_data[i], stall_d[i]);
                    end
                end
                stall_v[i] = out_valid[i] && !out_ready[i] && !clear;
                stall_d[i] = out_data[i];
                if (out_valid[i] && out_ready[i]) begin
                    total++;
                    n_out[i]++;
                    if (exp_q[i].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out[%0d]: got %0d want no output", i, out_data[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (out_data[i] !== e) begin
                            bad++;
                            $display("FAIL out_data[%0d]: got %0d want %0d", i, out_data[i], e);
                        end
                    end
                end
                if (clear) begin
                    m_fill[i] = 0;
                    m_wp[i] = 0;
                    exp_q[i].delete();
                end else if (in_valid[i] && in_ready[i]) begin
                    acc[i] = 1'b1;
                    e = m_hist[i][m_wp[i]];
                    m_hist[i][m_wp[i]] = in_data[i];
                    m_wp[i] = (m_wp[i] + 1) % lag_c[i];
                    if (m_fill[i] < lag_c[i]) m_fill[i]++;
                    else exp_q[i].push_back(ref_avg(int'(e), int'(in_data[i]), int'(rnd_mode)));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_data = '0;
        out_ready = '1;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (in_ready !== 3'b111 || out_valid !== 3'b000 || primed !== 3'b000 || out_data !== '0) begin
            bad++;
            $display("FAIL %s: got rdy=%b v=%b p=%b d=%h want rdy=111 v=000 p=000 d=0", tag, in_ready, out_valid, primed, out_data);
        end
    endtask

    task automatic test_reset();
        rnd_mode = 2'b01;
        do_reset();
        check_reset_values("reset_values");
    endtask

    // Ramp 0..15 on LAG=8: eight outputs k+4, first right after sample 8.
    task automatic test_ramp();
        int base;
        do_reset();
        rnd_mode = 2'b01;
        base = n_out[0];
        for (int k = 0; k < 16; k++) begin
            in_valid[0] = 1'b1;
            in_data[0] = DW'(k);
            tick();
            total++;
            if (primed[0] !== (k >= 7)) begin
                bad++;
                $display("FAIL ramp_primed k=%0d: got %b want %b", k, primed[0], k >= 7);
            end
            total++;
            if (out_valid[0] !== (k >= 8) || (k >= 8 && out_data[0] !== DW'(k - 4))) begin
                bad++;
                $display("FAIL ramp_out k=%0d: got v=%b d=%0d want v=%b d=%0d", k, out_valid[0], out_data[0], k >= 8, k - 4);
            end
        end
        idle_inputs();
        tick();
        tick();
        total++;
        if (n_out[0] - base != 8 || exp_q[0].size() != 0) begin
            bad++;
            $display("FAIL ramp_count: got %0d outputs want 8", n_out[0] - base);
        end
    endtask

    // Rounding table on the LAG=1 instance: each pair is (older, newer).
    task automatic test_rounding();
        int ta [10] = '{3, 3, 3, 2, 2, 2, 255, 255, 255, 255};
        int tb [10] = '{4, 4, 4, 3, 3, 3, 254, 255, 255, 255};
        int tm [10] = '{0, 1, 2, 0, 1, 2, 1, 0, 1, 2};
        int te [10] = '{3, 4, 4, 2, 3, 2, 255, 255, 255, 255};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            rnd_mode = tm[i][1:0];
            in_valid[2] = 1'b1;
            in_data[2] = ta[i][DW-1:0];
            tick();
            in_data[2] = tb[i][DW-1:0];
            tick();
            in_valid[2] = 1'b0;
            total++;
            if (out_valid[2] !== 1'b1 || out_data[2] !== te[i][DW-1:0]) begin
                bad++;
                $display("FAIL round (%0d,%0d) mode %0d: got v=%b d=%0d want %0d", ta[i], tb[i], tm[i], out_valid[2], out_data[2], te[i]);
            end
            tick();
        end
    endtask

    // 30 samples with out_ready dropped for cycles 15..19.
    task automatic test_backpressure();
        int sent, cyc, base;
        logic [DW-1:0] held;
        do_reset();
        base = n_out[0];
        sent = 0;
        cyc = 0;
        held = '0;
        while (sent < 30 && cyc < 200) begin
            rnd_mode = 2'($urandom_range(0, 3));
            out_ready[0] = !(cyc >= 15 && cyc < 20);
            in_valid[0] = 1'b1;
            in_data[0] = DW'($urandom_range(0, 255));
            tick();
            if (acc[0]) sent++;
            if (cyc >= 15 && cyc < 20) begin
                if (cyc == 15) held = out_data[0];
                total++;
                if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || out_data[0] !== held) begin
                    bad++;
                    $display("FAIL bp_stall cyc=%0d: got rdy=%b v=%b d=%0d want rdy=0 v=1 d=%0d", cyc, in_ready[0], out_valid[0], out_data[0], held);
                end
            end
            cyc++;
        end
        total++;
        if (sent != 30) begin
            bad++;
            $display("FAIL bp_timeout: got %0d samples want 30", sent);
        end
        idle_inputs();
        tick();
        tick();
        total++;
        if (n_out[0] - base != 22 || exp_q[0].size() != 0) begin
            bad++;
            $display("FAIL bp_count: got %0d outputs want 22", n_out[0] - base);
        end
    endtask

    // clear together with a sample after 12 samples on LAG=8.
    task automatic test_clear();
        logic [DW-1:0] post [9];
        do_reset();
        rnd_mode = 2'b01;
        for (int k = 0; k < 12; k++) begin
            in_valid[0] = 1'b1;
            in_data[0] = DW'($urandom_range(0, 255));
            tick();
        end
        in_data[0] = 8'hAA;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (out_valid[0] !== 1'b0 || primed[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_out: got v=%b p=%b want v=0 p=0", out_valid[0], primed[0]);
        end
        for (int k = 0; k < 9; k++) begin
            post[k] = DW'($urandom_range(0, 255));
            in_data[0] = post[k];
            tick();
            total++;
            if (k < 8 && out_valid[0] !== 1'b0) begin
                bad++;
                $display("FAIL clear_warmup k=%0d: got v=%b want 0", k, out_valid[0]);
            end else if (k == 8 && (out_valid[0] !== 1'b1 || out_data[0] !== ref_avg(int'(post[0]), int'(post[8]), 1))) begin
                bad++;
                $display("FAIL clear_first: got v=%b d=%0d want %0d", out_valid[0], out_data[0], ref_avg(int'(post[0]), int'(post[8]), 1));
            end
        end
        idle_inputs();
        tick();
    endtask

    // reset while a result is held, then warm-up restarts.
    task automatic test_reset_mid();
        do_reset();
        rnd_mode = 2'b10;
        for (int k = 0; k < 11; k++) begin
            in_valid[0] = 1'b1;
            in_data[0] = DW'($urandom_range(0, 255));
            tick();
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        tick();
        total++;
        if (out_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got v=%b want 1", out_valid[0]);
        end
        reset = 1'b1;
        tick();
        check_reset_values("mid_reset_values");
        reset = 1'b0;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_valid[0] = 1'b1;
            in_data[0] = DW'($urandom_range(0, 255));
            tick();
            total++;
            if (out_valid[0] !== (k == 8)) begin
                bad++;
                $display("FAIL mid_warmup k=%0d: got v=%b want %b", k, out_valid[0], k == 8);
            end
        end
        idle_inputs();
        tick();
    endtask

    // 40 random samples into LAG=5 and LAG=1 with random valid/ready/mode.
    task automatic test_random();
        int sent [NI];
        int base [NI];
        int cyc;
        do_reset();
        for (int i = 1; i < NI; i++) begin
            sent[i] = 0;
            base[i] = n_out[i];
        end
        cyc = 0;
        while ((sent[1] < 40 || sent[2] < 40) && cyc < 600) begin
            rnd_mode = 2'($urandom_range(0, 3));
            for (int i = 1; i < NI; i++) begin
                in_valid[i] = (sent[i] < 40) && ($urandom_range(0, 3) != 0);
                in_data[i] = DW'($urandom_range(0, 255));
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
            for (int i = 1; i < NI; i++) if (acc[i]) sent[i]++;
            cyc++;
        end
        idle_inputs();
        tick();
        tick();
        for (int i = 1; i < NI; i++) begin
            total++;
            if (sent[i] != 40 || n_out[i] - base[i] != 40 - lag_c[i] || exp_q[i].size() != 0) begin
                bad++;
                $display("FAIL random_count[%0d]: got sent=%0d outs=%0d want sent=40 outs=%0d", i, sent[i], n_out[i] - base[i], 40 - lag_c[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            n_out[i] = 0;
            m_wp[i] = 0;
            m_fill[i] = 0;
            stall_v[i] = 1'b0;
            for (int j = 0; j < 8; j++) m_hist[i][j] = '0;
        end
        reset = 1'b1;
        rnd_mode = 2'b01;
        idle_inputs();
        test_reset();
        test_ramp();
        test_rounding();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lagged_pair_averager.md
# lagged_pair_averager

Streaming, parametrised pairwise averager. Each accepted sample x[n] is averaged with the sample accepted LAG positions earlier, x[n-LAG], using a selectable rounding mode. History is held in a LAG-entry circular buffer and output uses a one-entry valid/ready register. The block sits in the sample datapath between a byte/word source and downstream filtering, and replaces batch collect-then-average processing with continuous one-sample-per-cycle throughput.

## Interface
- DATA_W, 8: sample width in bits (≥2).
- LAG, 8: averaging distance in samples (1..256). The buffer depth is LAG entries.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous restart of warm-up; the buffer is logically emptied.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DATA_W  sample x[n].
- rnd_mode  in  2  00 truncate, 01 round-half-up, 10 round-half-even, 11 same as 01.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result this cycle.
- out_data  out  DATA_W  average of x[n] and x[n-LAG].
- primed  out  1  history holds LAG samples, so the next accept produces an output.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no other stall.
- State:
  - wp: write pointer, 0..LAG-1, wraps from LAG-1 to 0.
  - fill: 0..LAG, saturating.
  - out register.
- On accept:
  - old = buf[wp]; buf[wp] <= in_data; wp advances.
  - If fill < LAG: fill increments and no output is produced (warm-up).
  - If fill == LAG: sum = old + in_data (DATA_W+1 bits). The out register is loaded and out_valid <= 1.
- Rounding, with s = sum and rnd_mode sampled in the accept cycle:
  - trunc: s[DATA_W:1].
  - half-up: s[DATA_W:1] + s[0].
  - half-even: s[DATA_W:1] + (s[0] & s[1]).
  - No saturation logic is needed; the maximum result is 2^DATA_W-1. The result must still be computed at DATA_W+1 bits before truncation.
- Output register:
  - out_valid clears when out_ready && !(new result loaded).
  - A simultaneous drain and load replaces the data and keeps out_valid = 1.
  - out_data is held stable while out_valid && !out_ready.
- primed = (fill == LAG).
- clear:
  - Sets fill <= 0, wp <= 0, out_valid <= 0. out_data and buffer contents are unchanged but treated as stale.
  - clear has priority over a same-cycle accept. That sample is discarded, and in_ready is still driven per the formula.
- reset: same effect as clear, plus out_data <= 0 and the buffer zeroed (or ignored; it is never read before being rewritten after warm-up).
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, primed = 0.
- Number of outputs for N accepted samples since the last clear/reset: max(0, N-LAG). Output k pairs sample k with sample k+LAG.

## Timing
- Latency: accept at edge t produces out_valid/out_data visible after edge t (registered, 1 cycle).
- Throughput: 1 sample/cycle when out_ready is held high.
- Warm-up: the first output follows the (LAG+1)-th accepted sample.
- Backpressure: with out_valid = 1 and out_ready = 0, in_ready = 0. No samples are lost or duplicated, and wp/fill are frozen.
- rnd_mode changes take effect on the next accept. Results already in the out register are unaffected.
- LAG = 1: every sample after the first produces the average with its immediate predecessor.
- Pointer wrap: wp wraps every LAG accepts, with no bubble at the wrap.

## Test plan
- DATA_W=8, LAG=8, rnd_mode=01, out_ready=1, feed 0..15 back-to-back -> exactly 8 outputs of 4,5,...,11; the first arrives 1 cycle after sample 8 is accepted; primed rises after sample 7.
- Rounding, pair (3,4), sum 7 -> trunc 3, half-up 4, half-even 4. Pair (2,3), sum 5 -> 2, 3, 2. Pair (255,254) half-up -> 255. Pair (255,255) -> 255 in all modes, with no wrap to 0.
- Backpressure: stream 30 samples, hold out_ready low for 5 cycles mid-stream -> in_ready is low, out_data is stable during the stall, and the output sequence matches the reference model exactly (no loss or duplication).
- clear after 12 samples, asserted together with in_valid -> out_valid = 0 next cycle, that sample is discarded, the next 8 samples produce nothing, and the 9th produces avg(post-clear sample 0, sample 8).
- reset asserted mid-stream with out_valid = 1 -> all outputs return to reset values next cycle and warm-up restarts. Also a 40-sample random run with LAG=5 and with LAG=1 (multiple wraps) compared against a scoreboard.
